// File: rtl/mini_src_control_unit.sv
// mini_src_control_unit: hardwired Moore sequencer (T0..T7 + HALT) driving the Mini SRC datapath strobes.
// Optional CU_MEM_WAIT_EN adds mem_ready; memory steps then stretch until it is high.
module mini_src_control_unit #(
  parameter int unsigned LINK_REG = 15,
  parameter logic [4:0]  ALU_ADD  = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
`ifdef CU_MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  input  logic [31:0] IR_Data,
  input  logic        CON_out,
  input  logic        stop,
  output logic        run,
  output logic        PC_in,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        HI_in,
  output logic        LO_in,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        OutPort_in,
  output logic        IncPC,
  output logic        CON_in,
  output logic        PC_out,
  output logic        Zhigh_out,
  output logic        Zlow_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        MDR_out,
  output logic        InPort_out,
  output logic        C_out,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_instruction_bits,
  output logic [15:0] RX_in_man
);
  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_t;
  typedef struct packed {
    logic pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in, incpc, con_in;
    logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
    logic read, write, gra, grb, grc, rin, rout, baout;
    logic [4:0]  alu;
    logic [15:0] rx;
  } ctl_t;

  step_t      step_q, step_d;
  logic       halt_q, halt_d;
  logic       last, hold, imm;
  ctl_t       c, g;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];
  assign imm       = op >= 5'd12;

  always_comb begin
    c    = '0;
    last = 1'b0;
    case (step_q)
      T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.incpc = 1'b1; c.z_in = 1'b1; end
      T1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; last = op == 5'd26 || op[4:2] == 3'b111; end
      default:
        if (op <= 5'd2) begin
          if (step_q == T3) begin c.grb = 1'b1; c.baout = 1'b1; c.y_in = 1'b1; end
          if (step_q == T4) begin c.c_out = 1'b1; c.alu = ALU_ADD; c.z_in = 1'b1; end
          if (step_q == T5) begin
            c.zlow_out = 1'b1;
            c.gra      = op == 5'd1;
            c.rin      = op == 5'd1;
            c.mar_in   = op != 5'd1;
            last       = op == 5'd1;
          end
          if (step_q == T6) begin c.read = op == 5'd0; c.gra = op == 5'd2; c.rout = op == 5'd2; c.mdr_in = 1'b1; end
          if (step_q == T7) begin
            c.mdr_out = op == 5'd0;
            c.gra     = op == 5'd0;
            c.rin     = op == 5'd0;
            c.write   = op == 5'd2;
            last      = 1'b1;
          end
        end else if (op <= 5'd14) begin
          if (step_q == T3) begin c.grb = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
          if (step_q == T4) begin
            c.grc   = !imm;
            c.rout  = !imm;
            c.c_out = imm;
            c.alu   = !imm ? op : op == 5'd12 ? 5'b00011 : op == 5'd13 ? 5'b00101 : 5'b00110;
            c.z_in  = 1'b1;
          end
          if (step_q == T5) begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; last = 1'b1; end
        end else if (op <= 5'd16) begin
          if (step_q == T3) begin c.gra = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
          if (step_q == T4) begin c.grb = 1'b1; c.rout = 1'b1; c.alu = op; c.z_in = 1'b1; end
          if (step_q == T5) begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
          if (step_q == T6) begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; last = 1'b1; end
        end else if (op <= 5'd18) begin
          if (step_q == T3) begin c.grb = 1'b1; c.rout = 1'b1; c.alu = op; c.z_in = 1'b1; end
          if (step_q == T4) begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; last = 1'b1; end
        end else if (op == 5'd19) begin
          if (step_q == T3) begin c.gra = 1'b1; c.rout = 1'b1; c.con_in = 1'b1; end
          if (step_q == T4) begin c.pc_out = 1'b1; c.y_in = 1'b1; end
          if (step_q == T5) begin c.c_out = 1'b1; c.alu = ALU_ADD; c.z_in = 1'b1; end
          if (step_q == T6) begin c.zlow_out = CON_out; c.pc_in = CON_out; last = 1'b1; end
        end else if (op == 5'd21) begin
          if (step_q == T3) begin c.pc_out = 1'b1; c.rx = 16'd1 << LINK_REG; end
          if (step_q == T4) begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; last = 1'b1; end
        end else if (op <= 5'd25) begin
          c.gra        = 1'b1;
          c.rout       = op == 5'd20 || op == 5'd23;
          c.rin        = !(op == 5'd20 || op == 5'd23);
          c.pc_in      = op == 5'd20;
          c.inport_out = op == 5'd22;
          c.outport_in = op == 5'd23;
          c.hi_out     = op == 5'd24;
          c.lo_out     = op == 5'd25;
          last         = 1'b1;
        end else begin
          last = 1'b1;
        end
    endcase
  end

  always_comb begin
    hold = 1'b0;
`ifdef CU_MEM_WAIT_EN
    hold = (c.read | c.write) & ~mem_ready;
`endif
    step_d = hold ? step_q : last ? T0 : step_t'(step_q + 3'd1);
    halt_d = ~hold & last & (stop | (op == 5'd27 && step_q == T3));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else if (!halt_q) begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

  assign g   = (clr || halt_q) ? '0 : c;
  assign run = clr | ~halt_q;
  assign {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in,
          PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
          Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_instruction_bits, RX_in_man} = g;
endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
- Hardwired Moore control sequencer for the Mini SRC datapath.
- It steps through fetch (T0–T2) and per-opcode execute steps (T3–T7), and drives every datapath control strobe that is currently hand-driven by directed benches.
- It sits beside `datapath`. It reads `IR_Data` and `CON_out`, and its outputs connect one-to-one to the datapath control ports.

Parameters:
- LINK_REG, 15: register written by jal; one-hot bit driven on RX_in_man.
- ALU_ADD, 5'b00011: alu_instruction_bits code for address/offset addition.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- IR_Data  in  32  current instruction. Opcode is [31:27], ra [26:23], rb [22:19], rc [18:15], br condition [20:19].
- CON_out  in  1  branch condition flip-flop result.
- stop  in  1  request halt at the next instruction boundary.
- run  out  1  high while not halted.
- PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in  out  1 each  register load strobes.
- PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out  out  1 each  bus drive strobes.
- Read, Write  out  1 each  memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select/encode controls.
- alu_instruction_bits  out  5  ALU operation.
- RX_in_man  out  16  one-hot direct register load; zero except at jal link.

Behaviour:
- State is a 3-bit step counter T0..T7 plus a HALT flag.
- Outputs are decoded combinationally from step, IR_Data[31:27] and CON_out. Every strobe is held for the whole step.
- Reset:
  - While clr=1 at an edge: step←T0, HALT←0.
  - While clr is high, all outputs are forced 0 and run=1.
  - Reset mid-instruction abandons that instruction; no partial write occurs after the clr edge.
- Fetch:
  - T0: PC_out, MAR_in, IncPC, Z_in.
  - T1: Zlow_out, PC_in, Read, MDR_in.
  - T2: MDR_out, IR_in.
- Execute, ld(00000) / ldi(00001):
  - T3: Grb, BAout, Y_in.
  - T4: C_out, alu=ALU_ADD, Z_in.
  - ldi, T5: Zlow_out, Gra, Rin; end.
  - ld: T5 Zlow_out, MAR_in; T6 Read, MDR_in; T7 MDR_out, Gra, Rin.
- Execute, st(00010):
  - T3/T4 as ld.
  - T5: Zlow_out, MAR_in.
  - T6: Gra, Rout, MDR_in (Read=0).
  - T7: Write.
- Execute, register ALU (00011–01011):
  - T3: Grb, Rout, Y_in.
  - T4: Grc, Rout, alu=opcode, Z_in.
  - T5: Zlow_out, Gra, Rin.
- Execute, addi/andi/ori (01100/01101/01110):
  - Same as register ALU, but T4 uses C_out and alu = 00011/00101/00110 respectively.
- Execute, mul/div (01111/10000):
  - T3: Gra, Rout, Y_in.
  - T4: Grb, Rout, alu=opcode, Z_in.
  - T5: Zlow_out, LO_in.
  - T6: Zhigh_out, HI_in.
- Execute, neg/not (10001/10010):
  - T3: Grb, Rout, alu=opcode, Z_in.
  - T4: Zlow_out, Gra, Rin.
- Execute, br(10011):
  - T3: Gra, Rout, CON_in.
  - T4: PC_out, Y_in.
  - T5: C_out, alu=ALU_ADD, Z_in.
  - T6: Zlow_out and PC_in only if CON_out=1; otherwise no strobes.
- Execute, single-step opcodes (all at T3):
  - jr(10100): Gra, Rout, PC_in.
  - in(10110): InPort_out, Gra, Rin.
  - out(10111): Gra, Rout, OutPort_in.
  - mfhi(11000): HI_out, Gra, Rin.
  - mflo(11001): LO_out, Gra, Rin.
- Execute, jal(10101):
  - T3: PC_out, RX_in_man=1<<LINK_REG.
  - T4: Gra, Rout, PC_in.
- Execute, nop(11010) and undefined opcodes (11100–11111):
  - Instruction ends after T2.
- Execute, halt(11011):
  - At T3, HALT←1.
  - While HALT, all outputs are 0 and run=0; leave only via clr.
- Sequencing:
  - After the last step of an instruction, step←T0.
  - stop=1 sampled on the last step sets HALT instead of starting the next fetch.
  - stop sampled on any other step is ignored.

Optional Feature:
- Macro CU_MEM_WAIT_EN.
- When defined:
  - Adds input mem_ready (1 bit).
  - Any step asserting Read or Write repeats, with strobes held, until mem_ready=1.
  - clr still overrides.
- When undefined:
  - No port; every memory step takes exactly one cycle.

Test Plan:
- clr pulse, then IR=0x08080045 (ldi R0,$45(R1)) → fetch strobes in T0–T2; T3 Grb+BAout+Y_in; T4 alu=00011+C_out+Z_in; T5 Zlow_out+Gra+Rin; next cycle back to T0.
- IR=0x01000095 (ld R2,$95(R0)) → Read+MDR_in in T1 and T6; T7 MDR_out+Gra+Rin; 8 cycles total.
- IR=0x9A800014 (brzr R5,$14):
  - CON_out=1 → T6 Zlow_out+PC_in.
  - CON_out=0 → T6 all strobes 0.
- IR=0x79880000 (mul R3,R1) → T4 alu=01111; T5 LO_in; T6 HI_in.
- IR=0xAB800000 (jal R7) → T3 RX_in_man=0x8000+PC_out; T4 Gra+Rout+PC_in. IR=0xD8000000 (halt) → run=0 and all outputs 0 from the next cycle.
- clr asserted during T5 of st → next cycle T0 with Write never asserted. With CU_MEM_WAIT_EN and mem_ready held low for 3 cycles at T1 → Read held 4 cycles.
